// File: rtl/conv_sched_ctrl.sv
// Convolution scheduler: loads NUM_K operand words and then walks every
// (kernel, row, column) output coordinate, stalling whenever the output FIFO is full.
module conv_sched_ctrl #(
  parameter int NUM_K = 6,
  parameter int OSZ   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_valid,
  output logic       ld_ready,
  output logic       buf_we,
  output logic [2:0] buf_waddr,
  input  logic       fifo_full,
  output logic       fifo_winc,
  output logic [2:0] eng_k,
  output logic [2:0] eng_y,
  output logic [2:0] eng_x,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DONE} state_t;

  localparam logic [2:0] K_LAST = 3'(NUM_K - 1);
  localparam logic [2:0] C_LAST = 3'(OSZ - 1);

  state_t     state_q, state_d;
  logic [2:0] load_cnt_q, load_cnt_d;
  logic [2:0] k_q, k_d, y_q, y_d, x_q, x_d;
  logic       accept, issue;

  assign ld_ready  = (state_q == S_LOAD);
  assign accept    = ld_valid && ld_ready;
  assign buf_we    = accept;
  assign buf_waddr = load_cnt_q;
  assign issue     = (state_q == S_COMPUTE) && !fifo_full;
  assign fifo_winc = issue;
  assign busy      = (state_q == S_COMPUTE);
  assign done      = (state_q == S_DONE);
  assign eng_k     = k_q;
  assign eng_y     = y_q;
  assign eng_x     = x_q;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    k_d        = k_q;
    y_d        = y_q;
    x_d        = x_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (load_cnt_q == K_LAST) begin
            load_cnt_d = 3'd0;
            state_d    = S_COMPUTE;
          end else begin
            load_cnt_d = load_cnt_q + 3'd1;
          end
        end
      end
      S_COMPUTE: begin
        // x is the fastest coordinate, k the slowest; the final wrap ends the frame.
        if (issue) begin
          if (x_q != C_LAST) begin
            x_d = x_q + 3'd1;
          end else begin
            x_d = 3'd0;
            if (y_q != C_LAST) begin
              y_d = y_q + 3'd1;
            end else begin
              y_d = 3'd0;
              if (k_q != K_LAST) begin
                k_d = k_q + 3'd1;
              end else begin
                k_d     = 3'd0;
                state_d = S_DONE;
              end
            end
          end
        end
      end
      S_DONE:  state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      load_cnt_q <= 3'd0;
      k_q        <= 3'd0;
      y_q        <= 3'd0;
      x_q        <= 3'd0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      k_q        <= k_d;
      y_q        <= y_d;
      x_q        <= x_d;
    end
  end

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Randomized bench for conv_sched_ctrl, checked against a frame-level model
// built on the ideal ordered list of output coordinates.
module tb_conv_sched_ctrl;

  localparam int NUM_K = 6;
  localparam int OSZ   = 5;
  localparam int TOTAL = NUM_K * OSZ * OSZ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_valid = 1'b0;
  logic       fifo_full = 1'b0;
  logic       ld_ready, buf_we, fifo_winc, busy, done;
  logic [2:0] buf_waddr, eng_k, eng_y, eng_x;

  conv_sched_ctrl #(.NUM_K(NUM_K), .OSZ(OSZ)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .fifo_full(fifo_full),
    .fifo_winc(fifo_winc), .eng_k(eng_k), .eng_y(eng_y), .eng_x(eng_x),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Ideal issue order and the model's view of the frame.
  int ref_k[TOTAL], ref_y[TOTAL], ref_x[TOTAL];
  int m_phase;   // 0 loading, 1 computing, 2 frame complete
  int m_loaded;
  int m_idx;
  int m_issued;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_loaded = 0;
    m_idx    = 0;
    m_issued = 0;
  endtask

  task automatic check_outputs();
    bit exp_we, exp_winc;
    int ek, ey, ex;
    exp_we   = (m_phase == 0) && ld_valid;
    exp_winc = (m_phase == 1) && !fifo_full;
    ek = (m_phase == 1) ? ref_k[m_idx] : 0;
    ey = (m_phase == 1) ? ref_y[m_idx] : 0;
    ex = (m_phase == 1) ? ref_x[m_idx] : 0;
    chk("ld_ready", 32'(ld_ready), 32'(m_phase == 0));
    chk("buf_we", 32'(buf_we), 32'(exp_we));
    if (exp_we) begin
      chk("buf_waddr", 32'(buf_waddr), 32'(m_loaded));
      $display("load  word %0d", m_loaded);
    end
    chk("fifo_winc", 32'(fifo_winc), 32'(exp_winc));
    chk("busy", 32'(busy), 32'(m_phase == 1));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("eng_k", 32'(eng_k), 32'(ek));
    chk("eng_y", 32'(eng_y), 32'(ey));
    chk("eng_x", 32'(eng_x), 32'(ex));
    if (exp_winc) $display("issue #%0d k=%0d y=%0d x=%0d", m_idx, eng_k, eng_y, eng_x);
  endtask

  task automatic step_model();
    case (m_phase)
      0: if (ld_valid) begin
           m_loaded++;
           if (m_loaded == NUM_K) begin
             m_loaded = 0;
             m_phase  = 1;
             m_issued = 0;
           end
         end
      1: if (!fifo_full) begin
           m_idx++;
           m_issued++;
           if (m_idx == TOTAL) begin
             m_idx   = 0;
             m_phase = 2;
           end
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
    chk({tag, "_buf_we"}, 32'(buf_we), 32'd0);
    chk({tag, "_fifo_winc"}, 32'(fifo_winc), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_coord"}, {23'd0, eng_k, eng_y, eng_x}, 32'd0);
  endtask

  // Modes: 0 ideal, 1 stall window at compute cycles 10..19, 2 random,
  // 3 random with reset at issue #77, 4 stall on the final coordinate.
  task automatic run_frame(input int mode);
    int  cyc = 0;
    int  ccyc = 0;
    int  stall = 0;
    bit  ended = 0;
    bit  saw_done = 0;
    while (!ended && cyc < 3000) begin
      cyc++;
      case (mode)
        0: begin ld_valid = (m_phase == 0); fifo_full = 1'b0; end
        1: begin
             ld_valid  = (m_phase == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
             fifo_full = (m_phase == 1) && ccyc >= 10 && ccyc <= 19;
           end
        4: begin
             ld_valid  = 1'($urandom_range(0, 1));
             fifo_full = (m_phase == 1) && (m_idx == TOTAL - 1) && (stall < 3);
             if (fifo_full) stall++;
           end
        default: begin
             ld_valid  = 1'($urandom_range(0, 1));
             fifo_full = 1'($urandom_range(0, 1));
           end
      endcase
      if (mode == 3 && m_phase == 1 && m_idx == 77) begin
        ld_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        model_reset();
        @(posedge clk);
        #1 check_reset_outputs("held_reset");
        rst_n = 1'b1;
        $display("reset at issue #77");
        ended = 1;
      end else begin
        @(negedge clk);
        check_outputs();
        if (m_phase == 1) ccyc++;
        if (m_phase == 2) begin
          ended = 1;
          saw_done = 1;
          chk("issue_count", 32'(m_issued), 32'(TOTAL));
          $display("frame done after %0d compute cycles", ccyc);
        end
        step_model();
        @(posedge clk);
        #1;
      end
    end
    chk("frame_ended", 32'(ended), 32'd1);
    if (saw_done && mode == 0) chk("compute_cycles_ideal", 32'(ccyc), 32'(TOTAL));
    if (saw_done && mode == 1) chk("compute_cycles_stall", 32'(ccyc), 32'(TOTAL + 10));
    if (saw_done && mode == 4) chk("compute_cycles_last", 32'(ccyc), 32'(TOTAL + 3));
  endtask

  initial begin
    int n = 0;
    for (int k = 0; k < NUM_K; k++)
      for (int y = 0; y < OSZ; y++)
        for (int x = 0; x < OSZ; x++) begin
          ref_k[n] = k; ref_y[n] = y; ref_x[n] = x;
          n++;
        end
    model_reset();
    #2 check_reset_outputs("por");
    @(posedge clk);
    #1 check_reset_outputs("por_hold");
    rst_n = 1'b1;

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(0);
    run_frame(4);
    for (int i = 0; i < 4; i++) run_frame(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
